// File: rtl/fft_seq_stream.sv
`default_nettype none
// ============================================================================
//  Module   : fft_seq_stream
//  Purpose  : Streaming sequencer for an iterative radix-2 FFT stage engine.
//             Loads N samples from a valid/ready input into the engine, runs
//             log2(N) stage passes (serially writing each pass result back),
//             then latches the final result into a private output buffer that
//             drains over a valid/ready output in natural or bit-reversed
//             order while the next frame is already loading.
//  Ports    : clk, rst (async, active-high)
//             s_data/s_valid/s_ready           input sample stream
//             m_data/m_valid/m_ready/m_last/m_index   output sample stream
//             eng_wr/eng_addr/eng_wdata        engine register write port
//             eng_start/eng_stage/eng_done     engine pass control
//             eng_rdata                        engine result bus (N words)
//             busy, frame_done                 status
//  Revision : 1.0  initial release
// ============================================================================
module fft_seq_stream #(
    parameter int N          = 32,
    parameter int MSB        = 16,
    parameter bit OUT_BITREV = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MSB-1:0]             s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [MSB-1:0]             m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic [$clog2(N)-1:0]       m_index,
    output logic                       eng_wr,
    output logic [$clog2(N)-1:0]       eng_addr,
    output logic [MSB-1:0]             eng_wdata,
    output logic                       eng_start,
    output logic [$clog2($clog2(N)):0] eng_stage,
    input  logic                       eng_done,
    input  logic [MSB*N-1:0]           eng_rdata,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int               c_LGN        = $clog2(N);
    localparam int               c_SW         = $clog2(c_LGN) + 1;
    localparam logic [c_LGN-1:0] c_LAST_IDX   = c_LGN'(N - 1);
    localparam logic [c_SW-1:0]  c_LAST_STAGE = c_SW'(c_LGN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_CALC     = 3'd2,
        S_FEEDBACK = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    state_t           r_state;
    logic [c_LGN-1:0] r_cnt;          // load index / feedback index
    logic [c_SW-1:0]  r_stage;
    logic             r_s_ready;
    logic             r_eng_start;
    logic             r_frame_done;

    logic [c_LGN-1:0] r_k;            // output position
    logic             r_valid;        // output buffer holds a frame
    logic [MSB-1:0]   r_buf [N];

    logic [MSB-1:0]   w_eng_word [N];
    logic [c_LGN-1:0] w_rev_k;
    logic [c_LGN-1:0] w_rd_idx;
    logic             w_accept;
    logic             w_drain;
    logic             w_buf_free;
    logic             w_buf_load;

    // r_s_ready is high exactly while in LOAD, so it doubles as the state gate.
    assign w_accept   = r_s_ready && s_valid;
    assign w_drain    = r_valid && m_ready;
    // The buffer counts as free when its last word leaves on this very edge,
    // which lets consecutive frames stream without a bubble.
    assign w_buf_free = !r_valid || (w_drain && (r_k == c_LAST_IDX));
    assign w_buf_load = (r_state == S_HOLD) && w_buf_free;

    generate
        for (genvar i = 0; i < N; i++) begin : g_buf
            assign w_eng_word[i] = eng_rdata[MSB*i +: MSB];

            always_ff @(posedge clk) begin
                if (w_buf_load) begin
                    r_buf[i] <= w_eng_word[i];
                end
            end
        end

        for (genvar b = 0; b < c_LGN; b++) begin : g_bitrev
            assign w_rev_k[b] = r_k[c_LGN-1-b];
        end
    endgenerate

    assign w_rd_idx = OUT_BITREV ? w_rev_k : r_k;

    // ------------------------------------------------------------------
    // Main sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_stage      <= '0;
            r_s_ready    <= 1'b0;
            r_eng_start  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_eng_start  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state   <= S_LOAD;
                    r_s_ready <= 1'b1;
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST_IDX) begin
                            r_stage     <= '0;
                            r_s_ready   <= 1'b0;
                            r_eng_start <= 1'b1;
                            r_state     <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (eng_done) begin
                        if (r_stage == c_LAST_STAGE) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                            r_state <= S_FEEDBACK;
                        end
                    end
                end
                S_FEEDBACK: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_IDX) begin
                        r_eng_start <= 1'b1;
                        r_state     <= S_CALC;
                    end
                end
                S_HOLD: begin
                    if (w_buf_free) begin
                        r_frame_done <= 1'b1;
                        r_s_ready    <= 1'b1;
                        r_state      <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output drain; runs independently of the main FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k     <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_drain) begin
                r_k <= r_k + 1'b1;  // wraps to 0 after the last word
                if (r_k == c_LAST_IDX) begin
                    r_valid <= 1'b0;
                end
            end
            if (w_buf_load) begin
                r_valid <= 1'b1;
            end
        end
    end

    // Engine write port: load samples in LOAD, pass results back in FEEDBACK.
    always_comb begin
        eng_wr    = 1'b0;
        eng_addr  = '0;
        eng_wdata = '0;
        if (w_accept) begin
            eng_wr    = 1'b1;
            eng_addr  = r_cnt;
            eng_wdata = s_data;
        end else if (r_state == S_FEEDBACK) begin
            eng_wr    = 1'b1;
            eng_addr  = r_cnt;
            eng_wdata = w_eng_word[r_cnt];
        end
    end

    // Buffer contents are not reset, so m_data is gated to read 0 when empty.
    assign m_data     = r_valid ? r_buf[w_rd_idx] : '0;
    assign m_valid    = r_valid;
    assign m_index    = r_k;
    assign m_last     = r_valid && (r_k == c_LAST_IDX);
    assign s_ready    = r_s_ready;
    assign eng_start  = r_eng_start;
    assign eng_stage  = r_stage;
    assign frame_done = r_frame_done;
    assign busy       = !((r_state == S_IDLE) ||
                          ((r_state == S_LOAD) && (r_cnt == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fft_seq_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_seq_stream
//  Purpose  : Self-checking bench for fft_seq_stream (N=8, MSB=16). Two
//             instances share all stimulus: one drains in natural order, one
//             in bit-reversed order. A behavioural engine adds 1 to every
//             register per pass, so each output word is input + log2(N).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fft_seq_stream;

    localparam int N   = 8;
    localparam int MSB = 16;
    localparam int LGN = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [MSB-1:0] s_data = '0;
    logic           s_valid = 1'b0;
    logic           m_ready = 1'b0;
    logic           spur_done = 1'b0;
    logic           eng_done_m = 1'b0;
    logic           eng_done;
    logic [MSB*N-1:0] eng_rdata = '0;

    logic           s_ready0, m_valid0, m_last0, eng_wr0, eng_start0, busy0, frame_done0;
    logic [MSB-1:0] m_data0, eng_wdata0;
    logic [2:0]     m_index0, eng_addr0, eng_stage0;
    logic           s_ready1, m_valid1, m_last1, eng_wr1, eng_start1, busy1, frame_done1;
    logic [MSB-1:0] m_data1, eng_wdata1;
    logic [2:0]     m_index1, eng_addr1, eng_stage1;

    assign eng_done = eng_done_m | spur_done;

    always #5 clk = ~clk;

    fft_seq_stream #(.N(N), .MSB(MSB), .OUT_BITREV(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
        .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready),
        .m_last(m_last0), .m_index(m_index0),
        .eng_wr(eng_wr0), .eng_addr(eng_addr0), .eng_wdata(eng_wdata0),
        .eng_start(eng_start0), .eng_stage(eng_stage0), .eng_done(eng_done),
        .eng_rdata(eng_rdata), .busy(busy0), .frame_done(frame_done0)
    );

    fft_seq_stream #(.N(N), .MSB(MSB), .OUT_BITREV(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready),
        .m_last(m_last1), .m_index(m_index1),
        .eng_wr(eng_wr1), .eng_addr(eng_addr1), .eng_wdata(eng_wdata1),
        .eng_start(eng_start1), .eng_stage(eng_stage1), .eng_done(eng_done),
        .eng_rdata(eng_rdata), .busy(busy1), .frame_done(frame_done1)
    );

    // Behavioural engine: done 3 cycles after start, result = register + 1.
    logic [MSB-1:0] eng_regs [N];
    int             eng_cnt = 0;
    always @(posedge clk) begin
        eng_done_m <= 1'b0;
        if (eng_wr0) eng_regs[eng_addr0] <= eng_wdata0;
        if (rst) eng_cnt <= 0;
        else if (eng_start0) eng_cnt <= 3;
        else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_done_m <= 1'b1;
                for (int k = 0; k < N; k++) eng_rdata[MSB*k +: MSB] <= eng_regs[k] + 16'd1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bitrev(input int k);
        int r = 0;
        for (int b = 0; b < LGN; b++) if ((k >> b) & 1) r |= 1 << (LGN - 1 - b);
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Output scoreboards and event counters
    // ------------------------------------------------------------------
    logic [MSB-1:0] exp0_q[$];
    logic [MSB-1:0] exp1_q[$];
    int stages_q[$];
    int idx0 = 0, idx1 = 0, n_out0 = 0, n_out1 = 0;
    int n_start = 0, n_fd = 0, n_wr = 0, n_last = 0;
    logic stall0 = 1'b0, stall1 = 1'b0;
    logic [MSB-1:0] hd0, hd1;
    logic [2:0]     hi0, hi1;

    always @(negedge clk) begin
        if (rst) begin
            idx0 = 0; idx1 = 0; stall0 = 1'b0; stall1 = 1'b0;
        end else begin
            if (eng_start0 === 1'b1) begin n_start++; stages_q.push_back(int'(eng_stage0)); end
            if (frame_done0 === 1'b1) n_fd++;
            if (eng_wr0 === 1'b1) n_wr++;
            if (stall0) begin chk("stall_data0", m_data0, hd0); chk("stall_index0", m_index0, hi0); end
            if (stall1) begin chk("stall_data1", m_data1, hd1); chk("stall_index1", m_index1, hi1); end
            if (m_valid0 === 1'b1 && m_ready) begin
                checks++;
                assert (exp0_q.size() != 0) else begin
                    errors++; $error("FAIL unexpected_out0: observed %0h expected none", m_data0);
                end
                if (exp0_q.size() != 0) chk("m_data0", m_data0, exp0_q.pop_front());
                chk("m_index0", m_index0, idx0);
                chk("m_last0", m_last0, idx0 == N - 1);
                if (m_last0) n_last++;
                idx0 = (idx0 + 1) % N; n_out0++;
            end
            if (m_valid1 === 1'b1 && m_ready) begin
                checks++;
                assert (exp1_q.size() != 0) else begin
                    errors++; $error("FAIL unexpected_out1: observed %0h expected none", m_data1);
                end
                if (exp1_q.size() != 0) chk("m_data1", m_data1, exp1_q.pop_front());
                chk("m_index1", m_index1, idx1);
                chk("m_last1", m_last1, idx1 == N - 1);
                idx1 = (idx1 + 1) % N; n_out1++;
            end
            stall0 = (m_valid0 === 1'b1) && !m_ready; hd0 = m_data0; hi0 = m_index0;
            stall1 = (m_valid1 === 1'b1) && !m_ready; hd1 = m_data1; hi1 = m_index1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit rand_ready = 1'b0;
    int s_st, s_fd, s_wr, s_last, s_out;

    task automatic tick();
        @(posedge clk); #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_outputs();
        chk("rst_s_ready", s_ready0, 0);     chk("rst_m_valid", m_valid0, 0);
        chk("rst_m_data", m_data0, 0);       chk("rst_m_index", m_index0, 0);
        chk("rst_m_last", m_last0, 0);       chk("rst_eng_wr", eng_wr0, 0);
        chk("rst_eng_addr", eng_addr0, 0);   chk("rst_eng_wdata", eng_wdata0, 0);
        chk("rst_eng_start", eng_start0, 0); chk("rst_eng_stage", eng_stage0, 0);
        chk("rst_busy", busy0, 0);           chk("rst_frame_done", frame_done0, 0);
        chk("rst_m_valid1", m_valid1, 0);    chk("rst_m_data1", m_data1, 0);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; s_valid = 1'b0; spur_done = 1'b0; s_data = 16'hFFFF;
        #1 check_reset_outputs();
        repeat (3) tick();
        check_reset_outputs();
        rst = 1'b0; s_data = '0;
    endtask

    task automatic snap();
        s_st = n_start; s_fd = n_fd; s_wr = n_wr; s_last = n_last; s_out = n_out0;
        stages_q.delete();
    endtask

    task automatic send_frame(input logic [MSB-1:0] d [N], input bit toggle,
                              input bit expect_out, input int spur_at);
        int g;
        if (expect_out)
            for (int k = 0; k < N; k++) begin
                exp0_q.push_back(d[k] + 16'(LGN));
                exp1_q.push_back(d[bitrev(k)] + 16'(LGN));
            end
        for (int i = 0; i < N; i++) begin
            if (toggle) begin s_valid = 1'b0; tick(); end
            s_data = d[i]; s_valid = 1'b1; spur_done = (i == spur_at);
            g = 0;
            while (!s_ready0 && g < 500) begin tick(); g++; end
            chk("s_ready_wait", s_ready0, 1);
            tick();
            spur_done = 1'b0;
        end
        s_valid = 1'b0; s_data = '0;
        chk("start_latency", eng_start0, 1);
        chk("start_stage", eng_stage0, 0);
    endtask

    task automatic wait_out(input int count);
        int g = 0;
        while ((n_out0 < s_out + count || n_out1 < s_out + count) && g < 3000) begin tick(); g++; end
        chk("out_count0", n_out0 - s_out, count);
        chk("out_count1", n_out1 - s_out, count);
        chk("exp_left0", exp0_q.size(), 0);
        chk("exp_left1", exp1_q.size(), 0);
    endtask

    task automatic check_stats(input int frames);
        chk("eng_starts", n_start - s_st, 3 * frames);
        chk("frame_dones", n_fd - s_fd, frames);
        chk("eng_writes", n_wr - s_wr, (N + (LGN - 1) * N) * frames);
        chk("m_last_count", n_last - s_last, frames);
        chk("stage_seq_len", stages_q.size(), 3 * frames);
        for (int i = 0; i < stages_q.size(); i++) chk("stage_seq", stages_q[i], i % LGN);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    logic [MSB-1:0] dseq [N];
    logic [MSB-1:0] d100 [N];
    logic [MSB-1:0] drnd [N];

    initial begin
        int g;
        for (int i = 0; i < N; i++) begin
            dseq[i] = 16'(i); d100[i] = 16'(100 + i); drnd[i] = 16'($urandom);
        end
        drnd[0] = 16'hFFFE;   // exercises modulo-2^16 wrap of the result

        // 1/2: natural and bit-reversed drain, m_ready held high
        do_reset();
        m_ready = 1'b1;
        tick();
        chk("idle_after_reset_busy", busy0, 0);
        snap();
        send_frame(dseq, 1'b0, 1'b1, -1);
        chk("calc_busy", busy0, 1);
        wait_out(N);
        check_stats(1);

        // 3: toggled s_valid, random m_ready, then random data
        rand_ready = 1'b1;
        snap();
        send_frame(dseq, 1'b1, 1'b1, -1);
        send_frame(drnd, 1'b1, 1'b1, -1);
        wait_out(2 * N);
        check_stats(2);

        // 4: back-to-back frames against a blocked output
        rand_ready = 1'b0; m_ready = 1'b0;
        repeat (2) tick();
        snap();
        send_frame(dseq, 1'b0, 1'b1, -1);
        send_frame(d100, 1'b0, 1'b1, -1);
        repeat (60) tick();
        chk("hold_s_ready", s_ready0, 0);
        chk("hold_busy", busy0, 1);
        chk("hold_frame_dones", n_fd - s_fd, 1);
        chk("hold_m_valid", m_valid0, 1);
        chk("hold_head", m_data0, 3);
        m_ready = 1'b1;
        wait_out(2 * N);
        check_stats(2);

        // 5: reset during stage-1 feedback, then replay scenario 1
        send_frame(dseq, 1'b0, 1'b0, -1);
        g = 0;
        while (!(eng_wr0 && !s_ready0 && eng_stage0 == 3'd1) && g < 200) begin tick(); g++; end
        chk("reach_feedback1", eng_stage0, 1);
        repeat (3) tick();
        do_reset();
        repeat (20) tick();
        chk("no_aborted_output", m_valid0, 0);
        snap();
        send_frame(dseq, 1'b0, 1'b1, -1);
        wait_out(N);
        check_stats(1);

        // 6: spurious eng_done during LOAD and FEEDBACK
        snap();
        send_frame(dseq, 1'b0, 1'b1, 3);
        g = 0;
        while (!(eng_wr0 && !s_ready0) && g < 200) begin tick(); g++; end
        chk("reach_feedback", eng_wr0, 1);
        repeat (2) tick();
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        tick();
        chk("no_stage_advance", eng_stage0, 1);
        chk("no_extra_start", eng_start0, 0);
        wait_out(N);
        check_stats(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fft_seq_stream.md
Name: fft_seq_stream

Overview:
- Streaming sequencer for the iterative FFT datapath.
- Accepts N samples over a valid/ready input stream and loads them into an external stage engine.
- Runs log2(N) radix-2 stage passes on the engine, writing each stage result back serially before the next pass.
- Latches the final result into an internal output buffer and drains it over a valid/ready output stream, in natural or bit-reversed order.
- The output buffer is separate from the engine, so loading of frame n+1 overlaps draining of frame n.

Parameters:
- N, 32: points per frame; power of two, at least 4.
- MSB, 16: sample word width in bits.
- OUT_BITREV, 0: 0 = drain buffer index k at output position k; 1 = drain buffer index bitrev(k) at position k.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- s_data  in  MSB  input sample.
- s_valid  in  1  input sample valid.
- s_ready  out  1  sequencer accepts an input sample.
- m_data  out  MSB  output sample.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts the output sample.
- m_last  out  1  asserted with the Nth output word of a frame.
- m_index  out  log2(N)  output position k of the current m_data.
- eng_wr  out  1  engine register write strobe.
- eng_addr  out  log2(N)  engine register write address.
- eng_wdata  out  MSB  engine register write data.
- eng_start  out  1  one-cycle pulse; starts stage pass eng_stage.
- eng_stage  out  log2(log2(N))+1  current stage index, 0..log2(N)-1.
- eng_done  in  1  one-cycle pulse; engine finished its pass.
- eng_rdata  in  MSB*N  engine result bus; word k is bits [MSB*k +: MSB].
- busy  out  1  asserted in every state except IDLE and LOAD-with-count-0.
- frame_done  out  1  one-cycle pulse when the output buffer is loaded.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE. Counters = 0. Output buffer invalid.
  - All outputs 0, including m_data and m_index.
  - A reset mid-frame or mid-drain discards all data; no partial output after release.
- IDLE: the first clock after reset release moves to LOAD. IDLE is never re-entered afterwards.
- LOAD:
  - s_ready = 1 while in LOAD. It is registered and goes low the cycle after the Nth accept.
  - On each s_valid&s_ready: eng_wr=1, eng_addr=cnt, eng_wdata=s_data, cnt++ (all in the same cycle, combinational).
  - After the Nth accept (cnt wraps to 0): stage=0, go to CALC.
- CALC:
  - eng_start pulses exactly once, on the first cycle in CALC. Then wait for eng_done.
  - eng_done outside CALC is ignored.
  - On eng_done with stage < log2(N)-1: stage++ and go to FEEDBACK.
  - On eng_done with stage = log2(N)-1: go to HOLD.
- FEEDBACK:
  - Runs N consecutive cycles, k = 0..N-1: eng_wr=1, eng_addr=k, eng_wdata=word k of eng_rdata.
  - eng_rdata is held stable by the engine until the next eng_start.
  - After k = N-1, go to CALC (new eng_start pulse).
- HOLD:
  - If the output buffer is free (invalid, or its last word is being accepted this cycle): copy eng_rdata into the buffer, mark it valid, pulse frame_done, go to LOAD.
  - Otherwise stay in HOLD. s_ready stays 0 in HOLD.
- Drain (independent of the main FSM):
  - m_valid = buffer valid.
  - m_data = buffer[OUT_BITREV ? bitrev(k) : k], m_index = k.
  - m_last = m_valid and (k = N-1).
  - On m_valid&m_ready: k++. After k = N-1 is accepted: k=0, buffer invalid.
  - With m_ready held high, the drain streams one word per cycle.
  - m_data and m_index are stable while m_valid&!m_ready.
- Latency:
  - Last input accept to first eng_start: 1 cycle.
  - Total frame time: N (load) + sum of engine latencies + (log2(N)-1)·N (feedback) + 1 (hold with buffer free).
- Widths: no arithmetic on sample data. Counters wrap modulo N. bitrev reverses log2(N) bits.

Test Plan:
Bench setup: N=8, MSB=16, behavioural engine. The engine sets done 3 cycles after eng_start, and its result word k = its register k + 1 (mod 2^16).
1. Reset, then samples 0..7 with s_valid held high, m_ready=1, OUT_BITREV=0 -> exactly 3 eng_start pulses (stage 0,1,2); FEEDBACK = 8 writes after stages 0 and 1; m_data 3..10 with m_index 0..7; m_last only on 10; one frame_done.
2. Same stimulus with OUT_BITREV=1 -> m_data sequence 3,7,5,9,4,8,6,10.
3. s_valid toggled 1010… during LOAD, m_ready random 50% -> same data as scenario 1; m_data and m_index held while stalled.
4. Two back-to-back frames (0..7, then 100..107) with m_ready=0 until frame 2 reaches HOLD -> FSM stays in HOLD, s_ready=0. Release m_ready: frame 1 drains 3..10, then frame 2 drains 103..110; frame_done pulses twice.
5. Assert rst during stage 1 FEEDBACK, then replay scenario 1 -> all outputs 0 during reset; no output from the aborted frame; scenario 1 result reproduced exactly.
6. Spurious eng_done during LOAD and FEEDBACK -> no stage advance, and no extra eng_start.
